// File: rtl/instr_fetch_buffer.sv
// Instruction fetch buffer: issues one memory read per accepted PC and queues
// the returning words in a 2-entry FIFO for the decoder; flush drops everything.
module instr_fetch_buffer #(
  parameter int W = 6,
  parameter int D = 32
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic [W-1:0] pc_addr,
  input  logic         pc_valid,
  output logic         pc_ready,
  input  logic         flush,
  output logic         mem_rd,
  output logic [W-1:0] mem_addr,
  input  logic [D-1:0] mem_rdata,
  output logic [D-1:0] instr,
  output logic [W-1:0] instr_pc,
  output logic         instr_valid,
  input  logic         instr_ready
);

  typedef struct packed {
    logic [D-1:0] instr;
    logic [W-1:0] pc;
  } entry_t;

  entry_t         fifo [2];
  logic [1:0]     count;
  logic           rptr, wptr;
  logic           inflight;
  logic [W-1:0]   tag;

  logic           accept, pop, wr;
  logic [2:0]     occ;

  // Buffered entries plus the outstanding read bound the number of accepts.
  assign occ         = {1'b0, count} + {2'b0, inflight};
  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid && instr_ready;
  assign pc_ready    = clr_n && !flush && ((occ < 3'd2) || pop);
  assign accept      = pc_valid && pc_ready;
  assign wr          = inflight && !flush;

  assign mem_rd   = accept;
  assign mem_addr = pc_addr;

  assign instr    = fifo[rptr].instr;
  assign instr_pc = fifo[rptr].pc;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= accept;
      if (accept) tag <= pc_addr;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= 2'd0;
      rptr  <= 1'b0;
      wptr  <= 1'b0;
      for (int i = 0; i < 2; i++) fifo[i] <= '0;
    end else if (flush) begin
      // Realign the read pointer so the next write lands at the head.
      count <= 2'd0;
      rptr  <= wptr;
    end else begin
      if (wr) begin
        fifo[wptr] <= '{instr: mem_rdata, pc: tag};
        wptr       <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({wr, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Scoreboard bench for instr_fetch_buffer: a predictor queues expected fetch
// results with their due cycle, a negedge monitor compares every DUT output.
module tb_instr_fetch_buffer;
  localparam int W = 6;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         clr_n;
  logic [W-1:0] pc_addr;
  logic         pc_valid;
  logic         pc_ready;
  logic         flush;
  logic         mem_rd;
  logic [W-1:0] mem_addr;
  logic [D-1:0] mem_rdata;
  logic [D-1:0] instr;
  logic [W-1:0] instr_pc;
  logic         instr_valid;
  logic         instr_ready;

  instr_fetch_buffer #(.W(W), .D(D)) dut (
    .clk(clk), .clr_n(clr_n), .pc_addr(pc_addr), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .flush(flush), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [D-1:0] data;
    logic [W-1:0] pc;
    int           due;
  } exp_t;

  exp_t         q[$];
  logic [D-1:0] memarr [64];
  int           cyc = 0;
  int           npass = 0;
  int           ntot = 0;
  bit           exp_acc = 1'b0;
  bit           last_acc = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Instruction memory: data one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= memarr[mem_addr];
    else        mem_rdata <= $urandom;
  end

  // Predictor: an accepted PC yields {mem[pc], pc} visible two cycles later.
  always @(posedge clk) begin
    last_acc <= exp_acc;
    if (!clr_n || flush) q.delete();
    else if (exp_acc) q.push_back('{memarr[pc_addr], pc_addr, cyc + 2});
    cyc <= cyc + 1;
  end

  always @(negedge clr_n) q.delete();

  // Monitor: compares outputs against the scoreboard head and occupancy.
  always @(negedge clk) begin
    bit vis, pop, rdy;
    if (!clr_n) begin
      chk("rst_pc_ready", pc_ready, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_instr_pc", instr_pc, 0);
      exp_acc = 1'b0;
    end else begin
      vis = (q.size() > 0) && (q[0].due <= cyc);
      pop = vis && instr_ready;
      chk("instr_valid", instr_valid, vis);
      if (vis) begin
        chk("instr", instr, q[0].data);
        chk("instr_pc", instr_pc, q[0].pc);
      end
      if (pop) void'(q.pop_front());
      rdy = !flush && (q.size() < 2);
      chk("pc_ready", pc_ready, rdy);
      chk("mem_rd", mem_rd, pc_valid && rdy);
      if (pc_valid && rdy) chk("mem_addr", mem_addr, pc_addr);
      exp_acc = pc_valid && rdy;
    end
  end

  task automatic step(input bit pv, input int a, input bit fl, input bit ir);
    pc_valid = pv; pc_addr = W'(a); flush = fl; instr_ready = ir;
    @(posedge clk); #1;
  endtask

  task automatic send(input int a, input bit ir);
    int n = 0;
    do begin
      step(1, a, 0, ir);
      n++;
    end while (!last_acc && n < 20);
    chk("accept_timeout", last_acc, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) memarr[i] = $urandom;
    memarr[0] = 32'hA0; memarr[1] = 32'hA1; memarr[2] = 32'hA2;
    memarr[3] = 32'hBAD;
    clr_n = 1'b0; pc_valid = 0; pc_addr = 0; flush = 0; instr_ready = 0;
    repeat (3) @(posedge clk);
    #1 clr_n = 1'b1;

    // streaming
    step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 2, 0, 1);
    idle(4);

    // backpressure: 7 waits until the decoder pops
    send(5, 0); send(6, 0);
    repeat (3) step(1, 7, 0, 0);
    send(7, 1);
    idle(5);

    // flush while a read is in flight
    send(3, 1);
    step(1, 20, 1, 1);
    send(20, 1);
    idle(4);

    // async reset mid-cycle with two buffered entries
    send(10, 0); send(11, 0);
    repeat (3) step(0, 0, 0, 0);
    #1 clr_n = 1'b0;
    #1;
    chk("async_instr_valid", instr_valid, 0);
    chk("async_pc_ready", pc_ready, 0);
    chk("async_instr", instr, 0);
    @(posedge clk); @(posedge clk); #1 clr_n = 1'b1;
    idle(5);

    // address wrap
    send(63, 1); send(0, 1);
    idle(4);

    // random traffic
    repeat (400)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 63),
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
    idle(6);
    chk("drained", q.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
